// File: rtl/lab5_fetch_unit.sv
// Instruction-fetch front end for the lab5 single-issue CPU.
//
// This block drives a word-aligned byte address into the instruction RAM.
// It captures the 16-bit word that comes back combinationally into an
// instruction register for decode. Fetch stops on the HALT encoding and
// resumes on a rising edge of the debounced RESUME button. The block also
// supports a single-step mode, branch redirects from execute, and a
// datapath stall.
//
// Ports
//   CLK        system clock, all state on posedge
//   RESET      synchronous, active-high reset
//   ADDR       byte address to instruction RAM (registered PC, bit0 = 0)
//   Q          instruction word returned combinationally for ADDR
//   STALL      datapath hold: PC, IR and state freeze, IR_VALID drops
//   BR_TAKEN   one-cycle redirect request from execute
//   BR_TARGET  redirect byte address (bit0 ignored)
//   STEP_MODE  1 = fetch one instruction per RESUME press
//   RESUME     debounced button level, rising edge is the event
//   IR         instruction register
//   IR_PC      byte address IR was fetched from
//   IR_VALID   IR holds a fresh instruction this cycle
//   HALTED     fetch is frozen on a HALT word
//   FETCH_CNT  count of valid fetches since reset, wraps
module lab5_fetch_unit #(
  parameter int unsigned PC_W      = 8,
  parameter logic [15:0] HALT_WORD = 16'h0001,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [PC_W-1:0]  ADDR,
  input  logic [15:0]      Q,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [PC_W-1:0]  BR_TARGET,
  input  logic             STEP_MODE,
  input  logic             RESUME,
  output logic [15:0]      IR,
  output logic [PC_W-1:0]  IR_PC,
  output logic             IR_VALID,
  output logic             HALTED,
  output logic [CNT_W-1:0] FETCH_CNT
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_STEP_WAIT = 2'd2
  } state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  ir_pc_q;
  logic [15:0]      ir_q;
  logic             ir_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             resume_q;

  logic             resume_rise_c;
  logic             is_halt_c;
  logic             fetch_c;
  logic [PC_W-1:0]  pc_inc_c;
  logic [PC_W-1:0]  br_pc_c;
  logic             unused_br_lsb;

  // The RESUME button acts on its rising edge only.
  // Holding the button adds no extra events.
  assign resume_rise_c = RESUME & ~resume_q;

  // A fetch happens on every RUN cycle.
  // In STEP_WAIT, a fetch happens once per press while step mode stays on.
  assign fetch_c = (state_q == ST_RUN) ||
                   ((state_q == ST_STEP_WAIT) && STEP_MODE && resume_rise_c);

  assign is_halt_c     = (Q == HALT_WORD);
  assign pc_inc_c      = pc_q + PC_W'(2);
  assign br_pc_c       = {BR_TARGET[PC_W-1:1], 1'b0};
  assign unused_br_lsb = BR_TARGET[0];

  // Fetch control, state and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
      resume_q   <= 1'b0;
    end else begin
      // Edge detect keeps tracking during a stall so that a press is not replayed afterwards.
      resume_q   <= RESUME;
      ir_valid_q <= 1'b0;

      if (!STALL) begin
        if (BR_TAKEN) begin
          // The word on Q belongs to the wrong path; drop it, even if it is HALT.
          pc_q <= br_pc_c;
        end else if (fetch_c) begin
          pc_q <= pc_inc_c;
          if (is_halt_c) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            ir_q       <= Q;
            ir_pc_q    <= pc_q;
            ir_valid_q <= 1'b1;
            cnt_q      <= cnt_q + CNT_W'(1);
            state_q    <= STEP_MODE ? ST_STEP_WAIT : ST_RUN;
          end
        end else begin
          case (state_q)
            ST_HALT: begin
              if (resume_rise_c) begin
                state_q  <= STEP_MODE ? ST_STEP_WAIT : ST_RUN;
                halted_q <= 1'b0;
              end
            end
            ST_STEP_WAIT: begin
              // Leaving step mode goes straight back to free-running fetch.
              if (!STEP_MODE) begin
                state_q <= ST_RUN;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign ADDR      = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign HALTED    = halted_q;
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// Directed testbench for lab5_fetch_unit.
// The instruction RAM is modelled as a combinational word array.
module tb_lab5_fetch_unit;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [15:0] I_SUB0 = 16'h2123;
  localparam logic [15:0] I_SUB1 = 16'h2456;
  localparam logic [15:0] I_ADDI = 16'h3789;
  localparam logic [15:0] I_SB   = 16'h5ABC;
  localparam logic [15:0] I_HALT = 16'h0001;
  localparam logic [15:0] I_ADD  = 16'h1DEF;

  logic             CLK;
  logic             RESET;
  logic [PC_W-1:0]  ADDR;
  logic [15:0]      Q;
  logic             STALL;
  logic             BR_TAKEN;
  logic [PC_W-1:0]  BR_TARGET;
  logic             STEP_MODE;
  logic             RESUME;
  logic [15:0]      IR;
  logic [PC_W-1:0]  IR_PC;
  logic             IR_VALID;
  logic             HALTED;
  logic [CNT_W-1:0] FETCH_CNT;

  logic [15:0] mem [128];

  int n_checks = 0;
  int n_errors = 0;

  lab5_fetch_unit #(
    .PC_W     (PC_W),
    .HALT_WORD(16'h0001),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ADDR     (ADDR),
    .Q        (Q),
    .STALL    (STALL),
    .BR_TAKEN (BR_TAKEN),
    .BR_TARGET(BR_TARGET),
    .STEP_MODE(STEP_MODE),
    .RESUME   (RESUME),
    .IR       (IR),
    .IR_PC    (IR_PC),
    .IR_VALID (IR_VALID),
    .HALTED   (HALTED),
    .FETCH_CNT(FETCH_CNT)
  );

  assign Q = mem[ADDR[7:1]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hF000 | 16'(i);
    mem[0] = I_SUB0;
    mem[1] = I_SUB1;
    mem[2] = I_ADDI;
    mem[3] = I_SB;
    mem[4] = I_HALT;
    mem[5] = I_ADD;

    RESET = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    STEP_MODE = 1'b0; RESUME = 1'b0;
    #2;

    // Reset values and the standard program up to HALT
    do_reset();
    check_eq("rst_addr",  32'(ADDR), 32'h0);
    check_eq("rst_ir",    32'(IR), 32'h0);
    check_eq("rst_irpc",  32'(IR_PC), 32'h0);
    check_eq("rst_valid", 32'(IR_VALID), 32'h0);
    check_eq("rst_halt",  32'(HALTED), 32'h0);
    check_eq("rst_cnt",   32'(FETCH_CNT), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("prog_valid%0d", i), 32'(IR_VALID), 32'h1);
      check_eq($sformatf("prog_irpc%0d", i), 32'(IR_PC), 32'(2 * i));
      check_eq($sformatf("prog_ir%0d", i), 32'(IR), 32'(mem[i]));
    end
    tick();
    check_eq("halt_flag",  32'(HALTED), 32'h1);
    check_eq("halt_addr",  32'(ADDR), 32'h0A);
    check_eq("halt_cnt",   32'(FETCH_CNT), 32'd4);
    check_eq("halt_valid", 32'(IR_VALID), 32'h0);
    check_eq("halt_ir",    32'(IR), 32'(I_SB));
    tick(); tick();
    check_eq("halt_hold",  32'(HALTED), 32'h1);
    check_eq("halt_hold_addr", 32'(ADDR), 32'h0A);
    RESUME = 1'b1;
    tick();
    check_eq("resume_run",   32'(HALTED), 32'h0);
    check_eq("resume_valid", 32'(IR_VALID), 32'h0);
    RESUME = 1'b0;
    tick();
    check_eq("resume_ir",    32'(IR), 32'(I_ADD));
    check_eq("resume_irpc",  32'(IR_PC), 32'h0A);
    check_eq("resume_vld",   32'(IR_VALID), 32'h1);
    check_eq("resume_cnt",   32'(FETCH_CNT), 32'd5);

    // Stall for three cycles after the second fetch
    do_reset();
    tick(); tick();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_addr%0d", i), 32'(ADDR), 32'h04);
      check_eq($sformatf("stall_valid%0d", i), 32'(IR_VALID), 32'h0);
      check_eq($sformatf("stall_cnt%0d", i), 32'(FETCH_CNT), 32'd2);
    end
    STALL = 1'b0;
    tick();
    check_eq("unstall_irpc", 32'(IR_PC), 32'h04);
    check_eq("unstall_ir",   32'(IR), 32'(I_ADDI));
    check_eq("unstall_cnt",  32'(FETCH_CNT), 32'd3);

    // Branch while the HALT word is on Q
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check_eq("br_pre_addr", 32'(ADDR), 32'h08);
    BR_TAKEN = 1'b1; BR_TARGET = 8'h13;
    tick();
    BR_TAKEN = 1'b0;
    check_eq("br_nohalt", 32'(HALTED), 32'h0);
    check_eq("br_addr",   32'(ADDR), 32'h12);
    check_eq("br_valid",  32'(IR_VALID), 32'h0);
    check_eq("br_cnt",    32'(FETCH_CNT), 32'd4);
    tick();
    check_eq("br_irpc", 32'(IR_PC), 32'h12);
    check_eq("br_ir",   32'(IR), 32'hF009);

    // Step mode with RESUME held through reset
    STEP_MODE = 1'b1; RESUME = 1'b1;
    do_reset();
    tick();
    check_eq("step_first_irpc", 32'(IR_PC), 32'h00);
    check_eq("step_first_cnt",  32'(FETCH_CNT), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check_eq("step_held_cnt",  32'(FETCH_CNT), 32'd1);
    check_eq("step_held_addr", 32'(ADDR), 32'h02);
    RESUME = 1'b0;
    tick();
    check_eq("step_rel_cnt", 32'(FETCH_CNT), 32'd1);
    RESUME = 1'b1;
    tick();
    check_eq("step_press_valid", 32'(IR_VALID), 32'h1);
    check_eq("step_press_irpc",  32'(IR_PC), 32'h02);
    check_eq("step_press_cnt",   32'(FETCH_CNT), 32'd2);
    for (int i = 0; i < 9; i++) tick();
    check_eq("step_hold10_cnt", 32'(FETCH_CNT), 32'd2);
    check_eq("step_hold10_vld", 32'(IR_VALID), 32'h0);
    RESUME = 1'b0;
    STEP_MODE = 1'b0;
    tick();
    check_eq("step_exit_valid", 32'(IR_VALID), 32'h0);
    tick();
    check_eq("step_exit_irpc", 32'(IR_PC), 32'h04);
    check_eq("step_exit_cnt",  32'(FETCH_CNT), 32'd3);

    // Branch to the top of the address space and wrap
    BR_TAKEN = 1'b1; BR_TARGET = 8'hFE;
    tick();
    BR_TAKEN = 1'b0;
    check_eq("wrap_br_addr", 32'(ADDR), 32'hFE);
    tick();
    check_eq("wrap_irpc", 32'(IR_PC), 32'hFE);
    check_eq("wrap_ir",   32'(IR), 32'hF07F);
    check_eq("wrap_addr", 32'(ADDR), 32'h00);
    tick();
    check_eq("wrap_next_irpc", 32'(IR_PC), 32'h00);
    check_eq("wrap_next_ir",   32'(IR), 32'(I_SUB0));

    // Reset while halted
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check_eq("rh_halted", 32'(HALTED), 32'h1);
    RESET = 1'b1;
    tick();
    check_eq("rh_halt_clr", 32'(HALTED), 32'h0);
    check_eq("rh_addr",     32'(ADDR), 32'h0);
    check_eq("rh_cnt",      32'(FETCH_CNT), 32'h0);
    check_eq("rh_ir",       32'(IR), 32'h0);
    RESET = 1'b0;
    tick();
    check_eq("rh_run_valid", 32'(IR_VALID), 32'h1);
    check_eq("rh_run_irpc",  32'(IR_PC), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
